crc16_share_ctrl: RTL and testbench

- Frame-level scheduler and sequencer for one shared bit-serial CRC-16 engine; the engine's state registers live inside this block.
- Two byte-stream requesters compete for the engine, and a round-robin arbiter grants at frame granularity.
- The controller accepts each byte through a valid/ready handshake, clocks it through the LFSR MSB-first over 8 cycles, and returns the final CRC tagged with the requester ID.
- It sits between packet-assembly logic and the link framer.

---
 rtl/crc16_share_ctrl_if.sv | 24 ++
 rtl/crc16_share_ctrl.sv | 111 +++++++++++
 tb/tb_crc16_share_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc16_share_ctrl_if.sv
// Requester/controller bundle for the shared CRC-16 engine.
// master = packet-assembly side, slave = crc16_share_ctrl.
interface crc16_share_ctrl_if;
    logic [1:0]  i_valid;
    logic [7:0]  i_data0;
    logic [7:0]  i_data1;
    logic [1:0]  i_last;
    logic [1:0]  o_ready;
    logic [1:0]  o_grant;
    logic        o_busy;
    logic [15:0] o_crc;
    logic        o_crc_valid;
    logic        o_crc_id;

    modport master (
        output i_valid, i_data0, i_data1, i_last,
        input  o_ready, o_grant, o_busy, o_crc, o_crc_valid, o_crc_id
    );

    modport slave (
        input  i_valid, i_data0, i_data1, i_last,
        output o_ready, o_grant, o_busy, o_crc, o_crc_valid, o_crc_id
    );
endinterface

// File: rtl/crc16_share_ctrl.sv
// Frame-granular round-robin sharing of one bit-serial CRC-16 engine
// between two byte-stream requesters; all outputs are registered.
module crc16_share_ctrl #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    crc16_share_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

    state_t      state;
    logic [15:0] crc;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        last_flag;
    logic        first_byte;
    logic        last_winner;

    logic        gidx;
    logic [7:0]  sel_data;
    logic        sel_last;
    logic        accept;
    logic        fb;
    logic [15:0] crc_next;
    logic        winner;

    // Granted index doubles as the mux select for the owner's byte lane
    always_comb begin
        gidx     = bus.o_grant[1];
        sel_data = gidx ? bus.i_data1 : bus.i_data0;
        sel_last = bus.i_last[gidx];
        accept   = |(bus.i_valid & bus.o_ready);
        fb       = crc[15] ^ shreg[7];
        crc_next = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        winner   = (&bus.i_valid) ? ~last_winner : bus.i_valid[1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            crc             <= 16'h0000;
            shreg           <= 8'h00;
            bit_cnt         <= 3'd0;
            last_flag       <= 1'b0;
            first_byte      <= 1'b0;
            last_winner     <= 1'b1;
            bus.o_ready     <= 2'b00;
            bus.o_grant     <= 2'b00;
            bus.o_busy      <= 1'b0;
            bus.o_crc       <= 16'h0000;
            bus.o_crc_valid <= 1'b0;
            bus.o_crc_id    <= 1'b0;
        end else begin
            bus.o_crc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.i_valid) begin
                        bus.o_grant <= winner ? 2'b10 : 2'b01;
                        bus.o_ready <= winner ? 2'b10 : 2'b01;
                        bus.o_busy  <= 1'b1;
                        first_byte  <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (accept) begin
                        shreg       <= sel_data;
                        last_flag   <= sel_last;
                        if (first_byte) begin
                            crc <= INIT;
                        end
                        first_byte  <= 1'b0;
                        bit_cnt     <= 3'd0;
                        bus.o_ready <= 2'b00;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc     <= crc_next;
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    // Final CRC is captured from crc_next so it appears on the same edge as the last shift
                    if (bit_cnt == 3'd7) begin
                        if (last_flag) begin
                            bus.o_crc       <= crc_next;
                            bus.o_crc_valid <= 1'b1;
                            bus.o_crc_id    <= gidx;
                            state           <= DONE;
                        end else begin
                            bus.o_ready <= bus.o_grant;
                            state       <= WAIT;
                        end
                    end
                end
                DONE: begin
                    last_winner <= gidx;
                    bus.o_grant <= 2'b00;
                    bus.o_busy  <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_share_ctrl.sv
// Scoreboard bench for crc16_share_ctrl: expected CRCs are queued when a frame
// is driven and popped when o_crc_valid pulses.
module tb_crc16_share_ctrl;

    logic i_clk = 1'b0;
    logic i_rst_n;

    always #5 i_clk = ~i_clk;

    crc16_share_ctrl_if ifA ();
    crc16_share_ctrl_if ifB ();

    logic [1:0] valid [2];
    logic [7:0] data0 [2];
    logic [7:0] data1 [2];
    logic [1:0] last  [2];

    assign ifA.i_valid = valid[0];
    assign ifA.i_data0 = data0[0];
    assign ifA.i_data1 = data1[0];
    assign ifA.i_last  = last[0];
    assign ifB.i_valid = valid[1];
    assign ifB.i_data0 = data0[1];
    assign ifB.i_data1 = data1[1];
    assign ifB.i_last  = last[1];

    crc16_share_ctrl dutA (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (ifA.slave)
    );

    crc16_share_ctrl #(.INIT(16'h0000)) dutB (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (ifB.slave)
    );

    typedef struct {
        logic        id;
        logic [15:0] crc;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t eA;
    exp_t eB;
    int   vectorCount = 0;
    int   missCount   = 0;
    int   cycle       = 0;
    int   acceptCycle [2][2];
    logic prevValidA  = 1'b0;
    logic prevValidB  = 1'b0;

    logic [7:0] frame [16];
    logic [7:0] fA    [16];
    logic [7:0] fB    [16];

    always @(posedge i_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] readyOf(input int d);
        return (d == 0) ? ifA.o_ready : ifB.o_ready;
    endfunction

    function automatic logic [1:0] grantOf(input int d);
        return (d == 0) ? ifA.o_grant : ifB.o_grant;
    endfunction

    function automatic logic busyOf(input int d);
        return (d == 0) ? ifA.o_busy : ifB.o_busy;
    endfunction

    // Byte-wise reference CRC (data folded into the high byte, then 8 conditional XORs)
    function automatic logic [15:0] crcModel(input logic [15:0] init, input logic [7:0] b [16], input int len);
        logic [15:0] c;
        c = init;
        for (int i = 0; i < len; i++) begin
            c = c ^ {b[i], 8'h00};
            for (int k = 0; k < 8; k++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    // Monitors: one scoreboard per DUT instance
    always @(negedge i_clk) begin
        if (ifA.o_crc_valid === 1'b1) begin
            checkOutput("A_crc_valid_pulse", prevValidA, 0);
            if (qA.size() == 0) begin
                checkOutput("A_unexpected_crc_valid", 1, 0);
            end else begin
                eA = qA.pop_front();
                checkOutput("A_crc", ifA.o_crc, eA.crc);
                checkOutput("A_crc_id", ifA.o_crc_id, eA.id);
                checkOutput("A_crc_latency", cycle - acceptCycle[0][eA.id], 8);
            end
        end
        prevValidA = ifA.o_crc_valid;
    end

    always @(negedge i_clk) begin
        if (ifB.o_crc_valid === 1'b1) begin
            checkOutput("B_crc_valid_pulse", prevValidB, 0);
            if (qB.size() == 0) begin
                checkOutput("B_unexpected_crc_valid", 1, 0);
            end else begin
                eB = qB.pop_front();
                checkOutput("B_crc", ifB.o_crc, eB.crc);
                checkOutput("B_crc_id", ifB.o_crc_id, eB.id);
                checkOutput("B_crc_latency", cycle - acceptCycle[1][eB.id], 8);
            end
        end
        prevValidB = ifB.o_crc_valid;
    end

    // Called at a negedge; returns at the 8th negedge after the accept edge
    task automatic sendByte(input int d, input int id, input logic [7:0] b, input logic lastFlag, input bit pulseReset);
        int         waitCnt;
        int         shiftReady;
        logic [1:0] r;
        waitCnt    = 0;
        shiftReady = 0;
        if (id == 0) data0[d] = b;
        else         data1[d] = b;
        last[d][id]  = lastFlag;
        valid[d][id] = 1'b1;
        while (waitCnt < 400) begin
            r = readyOf(d);
            checkOutput("ready_subset_grant", r & ~grantOf(d), 0);
            if (r[id]) break;
            @(negedge i_clk);
            waitCnt++;
        end
        if (waitCnt >= 400) begin
            checkOutput("ready_timeout", 0, 1);
            valid[d][id] = 1'b0;
            return;
        end
        @(posedge i_clk);
        #1;
        acceptCycle[d][id] = cycle;
        valid[d][id] = 1'b0;
        last[d][id]  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            if (pulseReset && k == 4) begin
                i_rst_n = 1'b0;
                #1;
                checkOutput("rst_mid_ready", ifA.o_ready, 0);
                checkOutput("rst_mid_grant", ifA.o_grant, 0);
                checkOutput("rst_mid_busy", ifA.o_busy, 0);
                checkOutput("rst_mid_crc", ifA.o_crc, 0);
                checkOutput("rst_mid_crc_valid", ifA.o_crc_valid, 0);
                checkOutput("rst_mid_crc_id", ifA.o_crc_id, 0);
                @(negedge i_clk);
                i_rst_n = 1'b1;
                @(negedge i_clk);
                return;
            end
            r = readyOf(d);
            if (r != 2'b00) shiftReady++;
        end
        checkOutput("ready_in_shift", shiftReady, 0);
    endtask

    task automatic applyStimulus(input int d, input int id, input logic [7:0] b [16], input int len,
                                 input logic [15:0] expCrc, input int gapCycles, input bit pushExp);
        logic [1:0] r;
        if (pushExp) begin
            if (d == 0) qA.push_back('{id[0], expCrc});
            else        qB.push_back('{id[0], expCrc});
        end
        for (int i = 0; i < len; i++) begin
            sendByte(d, id, b[i], (i == len - 1), 1'b0);
            if (i == 0) begin
                for (int g = 0; g < gapCycles; g++) begin
                    @(negedge i_clk);
                    r = readyOf(d);
                    checkOutput("gap_grant", grantOf(d), (id == 0) ? 2'b01 : 2'b10);
                    checkOutput("gap_ready_other", r[1 - id], 0);
                end
            end
        end
    endtask

    task automatic waitIdle(input int d);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (busyOf(d) && n < 100);
        if (n >= 100) checkOutput("idle_timeout", 0, 1);
        @(negedge i_clk);
    endtask

    initial begin
        #500000;
        $display("[TB] watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            valid[d] = 2'b00;
            data0[d] = 8'h00;
            data1[d] = 8'h00;
            last[d]  = 2'b00;
            acceptCycle[d][0] = 0;
            acceptCycle[d][1] = 0;
        end
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_ready", ifA.o_ready, 0);
        checkOutput("rst_grant", ifA.o_grant, 0);
        checkOutput("rst_busy", ifA.o_busy, 0);
        checkOutput("rst_crc", ifA.o_crc, 0);
        checkOutput("rst_crc_valid", ifA.o_crc_valid, 0);
        checkOutput("rst_crc_id", ifA.o_crc_id, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] single byte 'A' from requester 0");
        frame[0] = 8'h41;
        applyStimulus(0, 0, frame, 1, 16'hB915, 0, 1'b1);
        waitIdle(0);
        checkOutput("crc_hold", ifA.o_crc, 16'hB915);
        checkOutput("idle_grant", ifA.o_grant, 0);

        $display("[TB] \"123456789\" from requester 1");
        for (int i = 0; i < 9; i++) frame[i] = 8'h31 + 8'(i);
        applyStimulus(0, 1, frame, 9, 16'h29B1, 0, 1'b1);
        waitIdle(0);

        $display("[TB] \"123456789\" on INIT=0 instance");
        applyStimulus(1, 0, frame, 9, 16'h31C3, 0, 1'b1);
        waitIdle(1);

        $display("[TB] simultaneous two-byte frames from reset");
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        fA[0] = 8'hAA; fA[1] = 8'h55;
        fB[0] = 8'h12; fB[1] = 8'h34;
        qA.push_back('{1'b0, crcModel(16'hFFFF, fA, 2)});
        qA.push_back('{1'b1, crcModel(16'hFFFF, fB, 2)});
        fork
            applyStimulus(0, 0, fA, 2, 16'h0000, 0, 1'b0);
            applyStimulus(0, 1, fB, 2, 16'h0000, 0, 1'b0);
        join
        waitIdle(0);
        fA[0] = 8'h5A;
        fB[0] = 8'hC3;
        qA.push_back('{1'b0, crcModel(16'hFFFF, fA, 1)});
        qA.push_back('{1'b1, crcModel(16'hFFFF, fB, 1)});
        fork
            applyStimulus(0, 0, fA, 1, 16'h0000, 0, 1'b0);
            applyStimulus(0, 1, fB, 1, 16'h0000, 0, 1'b0);
        join
        waitIdle(0);

        $display("[TB] requester 0 stalls 20 cycles mid-frame");
        fA[0] = 8'h10; fA[1] = 8'h20; fA[2] = 8'h30;
        fB[0] = 8'h77;
        qA.push_back('{1'b0, crcModel(16'hFFFF, fA, 3)});
        qA.push_back('{1'b1, crcModel(16'hFFFF, fB, 1)});
        fork
            applyStimulus(0, 0, fA, 3, 16'h0000, 20, 1'b0);
            begin
                repeat (3) @(negedge i_clk);
                applyStimulus(0, 1, fB, 1, 16'h0000, 0, 1'b0);
            end
        join
        waitIdle(0);

        $display("[TB] reset during shift of byte 3");
        sendByte(0, 0, 8'h31, 1'b0, 1'b0);
        sendByte(0, 0, 8'h32, 1'b0, 1'b0);
        sendByte(0, 0, 8'h33, 1'b0, 1'b1);
        frame[0] = 8'h41;
        applyStimulus(0, 1, frame, 1, 16'hB915, 0, 1'b1);
        waitIdle(0);

        repeat (5) @(negedge i_clk);
        checkOutput("scoreboard_empty", qA.size() + qB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
